// File: rtl/waveform_scheduler.sv
// waveform_scheduler: paces generator sample requests, routes the selected response to data_o, applies config between samples.
module waveform_scheduler #(
    parameter int N_FRAC = 7,
    parameter int DIV_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [DIV_W-1:0]         divider_i,
    input  logic [1:0]               wave_sel_i,
    input  logic signed [N_FRAC:0]   cfg_phase_i,
    input  logic signed [N_FRAC:0]   cfg_amplitude_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic                     clear_i,
    output logic signed [N_FRAC:0]   gen_phase_o,
    output logic signed [N_FRAC:0]   gen_amplitude_o,
    output logic                     gen_next_data_strobe_o,
    input  logic signed [N_FRAC:0]   gen_saw_i,
    input  logic                     gen_saw_valid_i,
    input  logic signed [N_FRAC:0]   gen_tri_i,
    input  logic                     gen_tri_valid_i,
    input  logic signed [N_FRAC:0]   gen_sq_i,
    input  logic                     gen_sq_valid_i,
    output logic signed [N_FRAC:0]   data_o,
    output logic                     data_valid_strobe_o,
    output logic                     overrun_o,
    output logic                     busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [DIV_W-1:0] cnt, div_q;
    logic [1:0] sel_q;
    logic [N_FRAC:0] sh_phase, sh_amp, sel_data;
    logic sh_full, tick, hit, hs, apply, sel_valid;
    always_comb begin
        tick = state != IDLE && cnt == div_q;
        // the zero channel completes on the strobe cycle itself
        sel_valid = sel_q == 2'd0 ? gen_saw_valid_i : sel_q == 2'd1 ? gen_tri_valid_i :
                    sel_q == 2'd2 ? gen_sq_valid_i : gen_next_data_strobe_o;
        sel_data = sel_q == 2'd0 ? gen_saw_i : sel_q == 2'd1 ? gen_tri_i : sel_q == 2'd2 ? gen_sq_i : '0;
        hit = state == RESP && sel_valid;
        hs = cfg_valid_i && cfg_ready_o;
        apply = sh_full && (state == IDLE || (state == WAIT && !tick));
        state_n = state;
        case (state)
            IDLE:    state_n = enable_i ? WAIT : IDLE;
            WAIT:    state_n = !enable_i ? IDLE : tick ? RESP : WAIT;
            RESP:    state_n = !hit ? RESP : enable_i ? WAIT : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            div_q <= '0;
            sel_q <= '0;
            data_o <= '0;
            data_valid_strobe_o <= 1'b0;
            gen_next_data_strobe_o <= 1'b0;
            gen_phase_o <= '0;
            gen_amplitude_o <= '0;
            sh_phase <= '0;
            sh_amp <= '0;
            sh_full <= 1'b0;
            cfg_ready_o <= 1'b1;
            overrun_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            cnt <= (state == IDLE || tick || state_n == IDLE) ? '0 : cnt + 1'b1;
            div_q <= (state == IDLE || tick) ? divider_i : div_q;
            sel_q <= (state == WAIT && state_n == RESP) ? wave_sel_i : sel_q;
            gen_next_data_strobe_o <= state == WAIT && state_n == RESP;
            data_valid_strobe_o <= hit;
            data_o <= hit ? sel_data : data_o;
            overrun_o <= (state == RESP && tick) || (overrun_o && !clear_i);
            busy_o <= state_n != IDLE;
            // a new word can only land once the previous one has been applied
            sh_phase <= hs ? cfg_phase_i : sh_phase;
            sh_amp <= hs ? cfg_amplitude_i : sh_amp;
            sh_full <= hs || (sh_full && !apply);
            gen_phase_o <= apply ? sh_phase : gen_phase_o;
            gen_amplitude_o <= apply ? sh_amp : gen_amplitude_o;
            cfg_ready_o <= !sh_full && !hs;
        end
    end
endmodule

// File: tb/tb_waveform_scheduler.sv
// tb_waveform_scheduler: directed and random checks of waveform_scheduler against a countdown-based reference model.
module tb_waveform_scheduler;
    logic clk_i = 1'b0;
    logic rst_i, enable_i, cfg_valid_i, clear_i, cfg_ready_o;
    logic [7:0] divider_i;
    logic [1:0] wave_sel_i;
    logic signed [7:0] cfg_phase_i, cfg_amplitude_i, gen_phase_o, gen_amplitude_o;
    logic gen_next_data_strobe_o, gen_saw_valid_i, gen_tri_valid_i, gen_sq_valid_i;
    logic signed [7:0] gen_saw_i, gen_tri_i, gen_sq_i, data_o;
    logic data_valid_strobe_o, overrun_o, busy_o;

    waveform_scheduler #(.N_FRAC(7), .DIV_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .divider_i(divider_i),
        .wave_sel_i(wave_sel_i), .cfg_phase_i(cfg_phase_i), .cfg_amplitude_i(cfg_amplitude_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .clear_i(clear_i),
        .gen_phase_o(gen_phase_o), .gen_amplitude_o(gen_amplitude_o),
        .gen_next_data_strobe_o(gen_next_data_strobe_o),
        .gen_saw_i(gen_saw_i), .gen_saw_valid_i(gen_saw_valid_i),
        .gen_tri_i(gen_tri_i), .gen_tri_valid_i(gen_tri_valid_i),
        .gen_sq_i(gen_sq_i), .gen_sq_valid_i(gen_sq_valid_i),
        .data_o(data_o), .data_valid_strobe_o(data_valid_strobe_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0, checks = 0;
    int lat = 1, gcnt = 0;
    bit spur = 0;
    int m_mode, m_left, m_sel;
    logic [7:0] m_data, m_phase, m_amp, m_shp, m_sha;
    bit m_dv, m_gs, m_ready, m_ovr, m_busy, m_full, m_applied;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0 idle, 1 waiting for the period, 2 awaiting a response; m_left counts down to the next tick
    task automatic model_step();
        logic [7:0] dat[3];
        bit vld[3];
        bit tick, hs, apply, hit;
        int mode_n;
        if (rst_i) begin
            m_mode = 0; m_left = 0; m_sel = 0; m_data = 0; m_dv = 0; m_gs = 0;
            m_phase = 0; m_amp = 0; m_shp = 0; m_sha = 0; m_full = 0; m_applied = 0;
            m_ready = 1; m_ovr = 0; m_busy = 0;
            return;
        end
        dat[0] = gen_saw_i; dat[1] = gen_tri_i; dat[2] = gen_sq_i;
        vld[0] = gen_saw_valid_i; vld[1] = gen_tri_valid_i; vld[2] = gen_sq_valid_i;
        tick = m_mode != 0 && m_left == 0;
        hs = cfg_valid_i && m_ready;
        apply = m_full && (m_mode == 0 || (m_mode == 1 && !tick));
        hit = 0;
        if (m_mode == 2) begin
            if (m_sel == 3) hit = m_gs;
            else hit = vld[m_sel];
        end
        m_dv = hit;
        if (hit) begin
            if (m_sel == 3) m_data = 0;
            else m_data = dat[m_sel];
        end
        m_ready = hs ? 1'b0 : (m_ready || m_applied);
        m_applied = apply;
        if (apply) begin m_phase = m_shp; m_amp = m_sha; m_full = 0; end
        if (hs) begin m_shp = cfg_phase_i; m_sha = cfg_amplitude_i; m_full = 1; end
        m_ovr = (m_mode == 2 && tick) || (m_ovr && !clear_i);
        m_gs = 0;
        mode_n = m_mode;
        if (m_mode == 0) begin
            if (enable_i) begin mode_n = 1; m_left = int'(divider_i); end
        end else begin
            m_left = tick ? int'(divider_i) : m_left - 1;
            if (m_mode == 1) begin
                if (!enable_i) mode_n = 0;
                else if (tick) begin mode_n = 2; m_sel = int'(wave_sel_i); m_gs = 1; end
            end else if (hit) mode_n = enable_i ? 1 : 0;
        end
        m_mode = mode_n;
        m_busy = m_mode != 0;
    endtask

    task automatic fire();
        gen_saw_i = 8'($urandom); gen_tri_i = 8'($urandom); gen_sq_i = 8'($urandom);
        gen_saw_valid_i = 1; gen_tri_valid_i = 1; gen_sq_valid_i = 1;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        model_step();
        #1;
        chk("outputs", {data_o, data_valid_strobe_o, gen_next_data_strobe_o, gen_phase_o, gen_amplitude_o,
                        cfg_ready_o, overrun_o, busy_o},
                       {m_data, m_dv, m_gs, m_phase, m_amp, m_ready, m_ovr, m_busy});
        gen_saw_valid_i = 0; gen_tri_valid_i = 0; gen_sq_valid_i = 0;
        if (gcnt > 0) begin
            gcnt--;
            if (gcnt == 0) fire();
        end
        if (m_gs) begin
            if (lat == 0) fire();
            else gcnt = lat;
        end
        if (spur && $urandom_range(15) == 0) begin
            case ($urandom_range(2))
                0: begin gen_saw_valid_i = 1; gen_saw_i = 8'($urandom); end
                1: begin gen_tri_valid_i = 1; gen_tri_i = 8'($urandom); end
                default: begin gen_sq_valid_i = 1; gen_sq_i = 8'($urandom); end
            endcase
        end
    endtask

    task automatic wait_strobe(input string tag);
        int k = 0;
        while (!m_gs && k < 60) begin cyc(); k++; end
        chk(tag, k < 60, 1);
    endtask

    initial begin
        int ns, nd;
        rst_i = 1; enable_i = 0; divider_i = 0; wave_sel_i = 0; cfg_valid_i = 0; clear_i = 0;
        cfg_phase_i = 0; cfg_amplitude_i = 0;
        gen_saw_i = 0; gen_tri_i = 0; gen_sq_i = 0;
        gen_saw_valid_i = 0; gen_tri_valid_i = 0; gen_sq_valid_i = 0;
        repeat (3) cyc();
        chk("reset_ready", cfg_ready_o, 1);
        chk("reset_busy", busy_o, 0);
        rst_i = 0;

        divider_i = 4; wave_sel_i = 0; lat = 1; enable_i = 1; ns = 0;
        repeat (40) begin cyc(); ns += int'(gen_next_data_strobe_o); end
        chk("period5_strobes", ns, 7);
        chk("period5_no_overrun", overrun_o, 0);

        divider_i = 1; lat = 3;
        repeat (12) cyc();
        chk("overrun_set", overrun_o, 1);
        enable_i = 0;
        for (int k = 0; k < 20 && busy_o; k++) cyc();
        chk("overrun_drain_idle", busy_o, 0);
        clear_i = 1; cyc(); clear_i = 0; cyc();
        chk("overrun_cleared", overrun_o, 0);

        divider_i = 4; lat = 2; wave_sel_i = 1; enable_i = 1;
        wait_strobe("cfg_reach_resp");
        cfg_phase_i = 8'h10; cfg_amplitude_i = 8'h40; cfg_valid_i = 1;
        cyc();
        cfg_valid_i = 0;
        chk("cfg_ready_low", cfg_ready_o, 0);
        chk("cfg_phase_held", gen_phase_o, 0);
        repeat (12) cyc();
        chk("cfg_phase_applied", gen_phase_o, 8'h10);
        chk("cfg_amp_applied", gen_amplitude_o, 8'h40);
        chk("cfg_ready_back", cfg_ready_o, 1);

        wave_sel_i = 3; lat = 0;
        cyc();
        wait_strobe("zero_reach_resp");
        cyc();
        chk("zero_valid", data_valid_strobe_o, 1);
        chk("zero_data", data_o, 0);

        wave_sel_i = 0; lat = 2;
        cyc();
        wait_strobe("drop_reach_resp");
        enable_i = 0; nd = 0;
        repeat (4) begin cyc(); nd += int'(data_valid_strobe_o); end
        chk("drop_sample_delivered", nd, 1);
        chk("drop_idle", busy_o, 0);
        ns = 0;
        repeat (10) begin cyc(); ns += int'(gen_next_data_strobe_o); end
        chk("drop_no_strobes", ns, 0);

        enable_i = 1; lat = 3;
        wait_strobe("rst_reach_resp");
        cyc();
        rst_i = 1;
        #1;
        chk("async_reset_outputs", {data_o, data_valid_strobe_o, gen_next_data_strobe_o, gen_phase_o,
                                    gen_amplitude_o, cfg_ready_o, overrun_o, busy_o}, 29'h4);
        cyc();
        rst_i = 0; gcnt = 0; enable_i = 0;
        gen_saw_valid_i = 1; gen_saw_i = 8'h55;
        cyc();
        chk("rst_late_valid_0", data_valid_strobe_o, 0);
        cyc();
        chk("rst_late_valid_1", data_valid_strobe_o, 0);

        spur = 1;
        repeat (3000) begin
            enable_i = $urandom_range(7) != 0;
            divider_i = 8'($urandom_range(5));
            wave_sel_i = 2'($urandom_range(3));
            cfg_valid_i = $urandom_range(3) == 0;
            cfg_phase_i = 8'($urandom);
            cfg_amplitude_i = 8'($urandom);
            clear_i = $urandom_range(7) == 0;
            lat = $urandom_range(4);
            rst_i = $urandom_range(299) == 0;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
